quickq_seq: RTL
===============

Name: quickq_seq

Overview:
- Sequencer stage directly upstream of the QuickQ value router. It owns the single-port BRAM holding the sorted queue, with the ascending minimum at index 0.
- It accepts enqueue/dequeue requests and walks the array with a carry register, doing compare-swap on enqueue and shift-down on dequeue.
- It exports the current vrMode_t so the router and debug logic see the active phase.

Parameters:
- W, 8, data word width.
- D, 128, queue depth in entries.
- DW, $clog2(D), localparam, BRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- enq  in  1  enqueue request, sampled only when ready=1.
- deq  in  1  dequeue request, sampled only when ready=1.
- din  in  W  value to enqueue.
- ready  out  1  sequencer idle, request accepted this edge.
- dout  out  W  dequeued value (minimum).
- dout_valid  out  1  one-cycle pulse qualifying dout.
- full  out  1  count==D.
- empty  out  1  count==0.
- count  out  DW+1  number of valid entries.
- overflow  out  1  pulse: enq seen while full.
- underflow  out  1  pulse: deq seen while empty.
- bram_addr  out  DW  BRAM address.
- bram_we  out  1  BRAM write enable.
- bram_wdata  out  W  BRAM write data.
- bram_rdata  in  W  BRAM read data, 1-cycle read latency.
- vr_mode_o  out  vrMode_t  current router mode.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE, count=0, carry=0, idx=0.
  - dout=0, dout_valid=0, overflow=0, underflow=0, bram_we=0, bram_addr=0.
  - vr_mode_o=VR_DEF.
  - Reset mid-operation aborts the operation; BRAM contents are stale but unreachable because count=0.
- ready=1 only in IDLE. full, empty and count are registered and derived from count.
- Arbitration in IDLE:
  - deq and !empty → start dequeue.
  - else enq and !full → start enqueue.
  - enq && deq both high → dequeue wins; the enq is dropped and the caller reissues it.
  - deq while empty → underflow pulse, stay IDLE.
  - enq while full → overflow pulse, stay IDLE.
  - deq while empty with enq high and !full → underflow pulses and the enqueue starts in the same cycle.
- Enqueue (n = count at acceptance):
  - Acceptance: carry<=din, idx<=0. Next state is ENQ_LAST if n==0, else ENQ_RD.
  - ENQ_RD: bram_addr=idx, we=0.
  - ENQ_CMP: if carry < bram_rdata (strict), we=1, addr=idx, wdata=carry, carry<=bram_rdata. Then idx++. Go to ENQ_LAST if idx+1==n, else ENQ_RD.
  - ENQ_LAST: we=1, addr=n, wdata=carry, count<=n+1, go to IDLE.
  - Busy cycles = 2n+1.
  - Equal keys keep arrival order: a new entry lands after existing equal entries.
- Dequeue (n = count at acceptance):
  - DEQ_HEAD: addr=0.
  - DEQ_OUT: dout<=bram_rdata, dout_valid<=1 for one cycle, idx<=1. If n==1, count<=0 and go to IDLE; else DEQ_RD.
  - DEQ_RD: addr=idx.
  - DEQ_WR: we=1, addr=idx-1, wdata=bram_rdata, idx++. When idx+1==n, count<=n-1 and go to IDLE.
  - Busy cycles = 2n.
- vr_mode_o mapping:
  - IDLE → VR_DEF.
  - ENQ_RD and ENQ_CMP → VR_ENQ_COMPARE.
  - ENQ_LAST → VR_LAST.
  - DEQ_HEAD and DEQ_OUT → VR_DEQ_RD.
  - DEQ_RD and DEQ_WR → VR_DEQ_SWAP.
- Width rules:
  - Comparison is unsigned W-bit.
  - idx is DW+1 bits so it can reach D at the boundary.
  - bram_addr takes the low DW bits.
  - count never exceeds D.

Decomposition:
- quickQ_pkg: add qqSeqState_t (IDLE, ENQ_RD, ENQ_CMP, ENQ_LAST, DEQ_HEAD, DEQ_OUT, DEQ_RD, DEQ_WR). vrMode_t is reused unchanged.
- One natural sub-module: quickq_bram, a single-port synchronous RAM (W x D, 1-cycle read, write-first). The bench and top level use it. The sequencer itself is a single FSM.

Test Plan:
- Reset then idle → ready=1, empty=1, count=0, vr_mode_o=VR_DEF, dout_valid=0.
- Enqueue 30, 10, 20, 10 → BRAM[0..3]=10,10,20,30. count=4. The second 10 lands at index 1, and the 4th enqueue is busy 7 cycles.
- Dequeue four times after the above → dout=10,10,20,30, one dout_valid pulse each. Final empty=1, and the first dequeue is busy 8 cycles.
- Deq on empty, and enq after filling D=4 entries → underflow and overflow each pulse one cycle. count and BRAM are unchanged.
- enq=1 (din=5) and deq=1 in the same cycle with count=2 holding {7,9} → dout=7, count=1, BRAM[0]=9. The 5 is not inserted.
- rst_n=0 mid-enqueue at count=3 → next cycle state=IDLE, count=0, ready=1. A following enq 42 then deq returns 42.

Source files
------------

// File: rtl/quickq_pkg.sv
// Shared types for the QuickQ sequencer and router: router mode and sequencer FSM state.
package quickq_pkg;

  typedef enum logic [2:0] {
    VR_DEF         = 3'd0,
    VR_ENQ_COMPARE = 3'd1,
    VR_LAST        = 3'd2,
    VR_DEQ_RD      = 3'd3,
    VR_DEQ_SWAP    = 3'd4
  } vrMode_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENQ_RD   = 3'd1,
    ENQ_CMP  = 3'd2,
    ENQ_LAST = 3'd3,
    DEQ_HEAD = 3'd4,
    DEQ_OUT  = 3'd5,
    DEQ_RD   = 3'd6,
    DEQ_WR   = 3'd7
  } qqSeqState_t;

  function automatic vrMode_t vr_mode_of(input qqSeqState_t s);
    vrMode_t m;
    m = VR_DEF;
    case (s)
      IDLE:              m = VR_DEF;
      ENQ_RD, ENQ_CMP:   m = VR_ENQ_COMPARE;
      ENQ_LAST:          m = VR_LAST;
      DEQ_HEAD, DEQ_OUT: m = VR_DEQ_RD;
      DEQ_RD, DEQ_WR:    m = VR_DEQ_SWAP;
      default:           m = VR_DEF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/quickq_bram.sv
// Single-port synchronous RAM holding the sorted queue; 1-cycle read, write-first.
module quickq_bram #(
  parameter  int W  = 8,
  parameter  int D  = 128,
  localparam int DW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [DW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  // Storage array and read register; a write also returns the new word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
      rdata_q     <= wdata;
    end else begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/quickq_seq.sv
// QuickQ sequencer: keeps an ascending queue in an external single-port BRAM,
// inserting by compare-swap with a carry word and removing the head by shift-down.
module quickq_seq
  import quickq_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int D  = 128,
  localparam int DW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq,
  input  logic          deq,
  input  logic [W-1:0]  din,
  output logic          ready,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic [DW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic [DW-1:0] bram_addr,
  output logic          bram_we,
  output logic [W-1:0]  bram_wdata,
  input  logic [W-1:0]  bram_rdata,
  output vrMode_t       vr_mode_o
);

  localparam logic [DW:0] CNT_ZERO = {(DW+1){1'b0}};
  localparam logic [DW:0] CNT_ONE  = (DW+1)'(1);
  localparam logic [DW:0] CNT_MAX  = (DW+1)'(D);

  qqSeqState_t state_q, state_d;
  logic [DW:0]  count_q, count_d;
  logic [DW:0]  idx_q, idx_d;
  logic [W-1:0] carry_q, carry_d;
  logic [W-1:0] dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;
  logic         ready_q, ready_d;
  logic         full_q, full_d;
  logic         empty_q, empty_d;
  vrMode_t      vr_mode_q, vr_mode_d;

  logic [DW:0]  idx_inc_s;
  logic [DW:0]  idx_dec_s;

  assign idx_inc_s = idx_q + CNT_ONE;
  assign idx_dec_s = idx_q - CNT_ONE;

  // Next-state, datapath and BRAM port control; the BRAM port must follow
  // bram_rdata within the same cycle so it stays combinational.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    bram_addr    = {DW{1'b0}};
    bram_we      = 1'b0;
    bram_wdata   = {W{1'b0}};

    case (state_q)
      IDLE: begin
        underflow_d = deq && empty_q;
        if (deq && !empty_q) begin
          state_d = DEQ_HEAD;
        end else if (enq && !full_q) begin
          carry_d = din;
          idx_d   = CNT_ZERO;
          state_d = (count_q == CNT_ZERO) ? ENQ_LAST : ENQ_RD;
        end else begin
          overflow_d = enq && full_q;
        end
      end
      ENQ_RD: begin
        bram_addr = idx_q[DW-1:0];
        state_d   = ENQ_CMP;
      end
      ENQ_CMP: begin
        // Strict compare: equal keys pass by, so arrival order is kept.
        if (carry_q < bram_rdata) begin
          bram_we    = 1'b1;
          bram_addr  = idx_q[DW-1:0];
          bram_wdata = carry_q;
          carry_d    = bram_rdata;
        end else begin
          carry_d = carry_q;
        end
        idx_d   = idx_inc_s;
        state_d = (idx_inc_s == count_q) ? ENQ_LAST : ENQ_RD;
      end
      ENQ_LAST: begin
        bram_we    = 1'b1;
        bram_addr  = count_q[DW-1:0];
        bram_wdata = carry_q;
        count_d    = count_q + CNT_ONE;
        state_d    = IDLE;
      end
      DEQ_HEAD: begin
        bram_addr = {DW{1'b0}};
        state_d   = DEQ_OUT;
      end
      DEQ_OUT: begin
        dout_d       = bram_rdata;
        dout_valid_d = 1'b1;
        idx_d        = CNT_ONE;
        if (count_q == CNT_ONE) begin
          count_d = CNT_ZERO;
          state_d = IDLE;
        end else begin
          state_d = DEQ_RD;
        end
      end
      DEQ_RD: begin
        bram_addr = idx_q[DW-1:0];
        state_d   = DEQ_WR;
      end
      DEQ_WR: begin
        bram_we    = 1'b1;
        bram_addr  = idx_dec_s[DW-1:0];
        bram_wdata = bram_rdata;
        idx_d      = idx_inc_s;
        if (idx_inc_s == count_q) begin
          count_d = count_q - CNT_ONE;
          state_d = IDLE;
        end else begin
          state_d = DEQ_RD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d   = (state_d == IDLE);
    full_d    = (count_d == CNT_MAX);
    empty_d   = (count_d == CNT_ZERO);
    vr_mode_d = vr_mode_of(state_d);
  end

  // State and registered status/output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= CNT_ZERO;
      idx_q        <= CNT_ZERO;
      carry_q      <= {W{1'b0}};
      dout_q       <= {W{1'b0}};
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ready_q      <= 1'b1;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      vr_mode_q    <= VR_DEF;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ready_q      <= ready_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      vr_mode_q    <= vr_mode_d;
    end
  end

  assign ready      = ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign vr_mode_o  = vr_mode_q;

endmodule
